// File: rtl/bus_fifo_terminal_if.sv
// Bus-terminal signal bundle: host TX/RX FIFO access plus the bus driver's
// pop/pndng/D_pop read handshake and push/D_push write path.
interface bus_fifo_terminal_if #(
  parameter int pckg_sz = 16
);
  logic               host_push;
  logic [pckg_sz-1:0] host_din;
  logic               host_full;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;
  logic               rx_pndng;
  logic [pckg_sz-1:0] rx_dout;
  logic               rx_pop;
  logic               tx_ovf;
  logic               tx_udf;
  logic               rx_ovf;
  logic [7:0]         rx_drop_cnt;

  modport slave (
    input  host_push, host_din, pop, push, D_push, rx_pop,
    output host_full, pndng, D_pop, rx_pndng, rx_dout,
           tx_ovf, tx_udf, rx_ovf, rx_drop_cnt
  );

  modport master (
    output host_push, host_din, pop, push, D_push, rx_pop,
    input  host_full, pndng, D_pop, rx_pndng, rx_dout,
           tx_ovf, tx_udf, rx_ovf, rx_drop_cnt
  );
endinterface

// File: rtl/bus_fifo_terminal.sv
// Device-side bus terminal: host-filled TX FIFO drained by the bus driver and
// an address-filtered RX FIFO drained by the host; both first-word fall-through.
module bus_fifo_terminal #(
  parameter int         pckg_sz = 16,
  parameter int         depth   = 8,
  parameter logic [7:0] id      = 8'd0,
  parameter logic [7:0] bcast   = 8'hFF
) (
  input logic                clk,
  input logic                reset,
  bus_fifo_terminal_if.slave bus
);
  localparam int              AW     = $clog2(depth);
  localparam int              CW     = AW + 1;
  localparam logic [CW-1:0]   FULL_C = CW'(depth);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // TX FIFO
  logic [pckg_sz-1:0] r_tx_mem [depth];
  logic [AW-1:0]      r_tx_wr, r_tx_rd;
  logic [CW-1:0]      r_tx_cnt;
  logic               r_tx_full, r_tx_ovf, r_tx_udf;
  logic               w_tx_empty, w_tx_pop_ok, w_tx_push_ok;
  logic [CW-1:0]      w_tx_cnt_nxt;

  assign w_tx_empty   = (r_tx_cnt == '0);
  assign w_tx_pop_ok  = bus.pop && !w_tx_empty;
  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign w_tx_push_ok = bus.host_push && (!r_tx_full || w_tx_pop_ok);
  assign w_tx_cnt_nxt = r_tx_cnt + CW'(w_tx_push_ok) - CW'(w_tx_pop_ok);

  always_ff @(posedge clk) begin
    if (w_tx_push_ok) r_tx_mem[r_tx_wr] <= bus.host_din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wr   <= '0;
      r_tx_rd   <= '0;
      r_tx_cnt  <= '0;
      r_tx_full <= 1'b0;
      r_tx_ovf  <= 1'b0;
      r_tx_udf  <= 1'b0;
    end else begin
      if (w_tx_push_ok) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop_ok)  r_tx_rd <= r_tx_rd + 1'b1;
      r_tx_cnt  <= w_tx_cnt_nxt;
      r_tx_full <= (w_tx_cnt_nxt == FULL_C);
      if (bus.host_push && !w_tx_push_ok) r_tx_ovf <= 1'b1;
      if (bus.pop && w_tx_empty)          r_tx_udf <= 1'b1;
    end
  end

  assign bus.pndng     = !w_tx_empty;
  assign bus.D_pop     = w_tx_empty ? '0 : r_tx_mem[r_tx_rd];
  assign bus.host_full = r_tx_full;
  assign bus.tx_ovf    = r_tx_ovf;
  assign bus.tx_udf    = r_tx_udf;

  // RX FIFO
  logic [pckg_sz-1:0] r_rx_mem [depth];
  logic [AW-1:0]      r_rx_wr, r_rx_rd;
  logic [CW-1:0]      r_rx_cnt;
  logic               r_rx_ovf;
  logic [7:0]         r_rx_drop;
  logic               w_rx_empty, w_rx_full, w_rx_hit, w_rx_pop_ok, w_rx_wr_ok;

  assign w_rx_empty  = (r_rx_cnt == '0);
  assign w_rx_full   = (r_rx_cnt == FULL_C);
  assign w_rx_hit    = (bus.D_push[pckg_sz-1 -: 8] == id) ||
                       (bus.D_push[pckg_sz-1 -: 8] == bcast);
  assign w_rx_pop_ok = bus.rx_pop && !w_rx_empty;
  assign w_rx_wr_ok  = bus.push && w_rx_hit && (!w_rx_full || w_rx_pop_ok);

  always_ff @(posedge clk) begin
    if (w_rx_wr_ok) r_rx_mem[r_rx_wr] <= bus.D_push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_wr   <= '0;
      r_rx_rd   <= '0;
      r_rx_cnt  <= '0;
      r_rx_ovf  <= 1'b0;
      r_rx_drop <= '0;
    end else begin
      if (w_rx_wr_ok)  r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop_ok) r_rx_rd <= r_rx_rd + 1'b1;
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_wr_ok) - CW'(w_rx_pop_ok);
      if (bus.push && w_rx_hit && !w_rx_wr_ok) r_rx_ovf <= 1'b1;
      // Filtered and overflowed pushes both count as drops.
      if (bus.push && !w_rx_wr_ok) r_rx_drop <= sat_inc8(r_rx_drop);
    end
  end

  assign bus.rx_pndng    = !w_rx_empty;
  assign bus.rx_dout     = w_rx_empty ? '0 : r_rx_mem[r_rx_rd];
  assign bus.rx_ovf      = r_rx_ovf;
  assign bus.rx_drop_cnt = r_rx_drop;
endmodule

// File: tb/tb_bus_fifo_terminal.sv
// Scoreboard bench for bus_fifo_terminal (depth 8, id 3): stimulus queues the
// expected packets, a negedge monitor checks every consumed FIFO head.
module tb_bus_fifo_terminal;
  localparam int W = 16;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_fifo_terminal_if #(.pckg_sz(W)) ifc ();

  bus_fifo_terminal #(.pckg_sz(W), .depth(D), .id(8'h03), .bcast(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] tx_q[$];
  logic [W-1:0] rx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.host_push = 1'b0;
    ifc.host_din  = '0;
    ifc.pop       = 1'b0;
    ifc.push      = 1'b0;
    ifc.D_push    = '0;
    ifc.rx_pop    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tx_q.delete();
    rx_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pndng"},    32'(ifc.pndng),       32'd0);
    check({tag, "_D_pop"},    32'(ifc.D_pop),       32'd0);
    check({tag, "_rx_pndng"}, 32'(ifc.rx_pndng),    32'd0);
    check({tag, "_rx_dout"},  32'(ifc.rx_dout),     32'd0);
    check({tag, "_full"},     32'(ifc.host_full),   32'd0);
    check({tag, "_flags"},    32'({ifc.tx_ovf, ifc.tx_udf, ifc.rx_ovf}), 32'd0);
    check({tag, "_drop"},     32'(ifc.rx_drop_cnt), 32'd0);
  endtask

  // Monitor: the driver samples D_pop/rx_dout in the cycle it pops.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (ifc.pop && ifc.pndng) begin
        if (tx_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_unexpected: got %h expected none", ifc.D_pop);
        end else check("tx_data", 32'(ifc.D_pop), 32'(tx_q.pop_front()));
      end
      if (ifc.rx_pop && ifc.rx_pndng) begin
        if (rx_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rx_unexpected: got %h expected none", ifc.rx_dout);
        end else check("rx_data", 32'(ifc.rx_dout), 32'(rx_q.pop_front()));
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_reset_state("rst");

    // Two host pushes, then two pops
    ifc.host_push = 1'b1; ifc.host_din = 16'h0123; tx_q.push_back(16'h0123);
    step();
    check("t1_pndng", 32'(ifc.pndng), 32'd1);
    check("t1_head",  32'(ifc.D_pop), 32'h0123);
    ifc.host_din = 16'h0456; tx_q.push_back(16'h0456);
    step();
    ifc.host_push = 1'b0;
    ifc.pop = 1'b1;
    step();
    check("t1_head2", 32'(ifc.D_pop), 32'h0456);
    step();
    ifc.pop = 1'b0;
    check("t1_empty_pndng", 32'(ifc.pndng), 32'd0);
    check("t1_empty_D_pop", 32'(ifc.D_pop), 32'd0);

    // Overfill TX, then push+pop while full
    for (int i = 0; i < 9; i++) begin
      ifc.host_push = 1'b1;
      ifc.host_din  = 16'h1000 + 16'(i);
      if (i < 8) tx_q.push_back(16'h1000 + 16'(i));
      step();
      if (i == 6) check("t2_not_full", 32'(ifc.host_full), 32'd0);
      if (i == 7) check("t2_full",     32'(ifc.host_full), 32'd1);
    end
    ifc.host_push = 1'b0;
    check("t2_tx_ovf", 32'(ifc.tx_ovf), 32'd1);
    ifc.host_push = 1'b1; ifc.host_din = 16'h1009; tx_q.push_back(16'h1009);
    ifc.pop = 1'b1;
    step();
    ifc.host_push = 1'b0;
    ifc.pop = 1'b0;
    check("t2_full_after_pp", 32'(ifc.host_full), 32'd1);
    check("t2_ovf_kept",      32'(ifc.tx_ovf),    32'd1);
    ifc.pop = 1'b1;
    repeat (8) step();
    ifc.pop = 1'b0;
    check("t2_drained", 32'(ifc.pndng), 32'd0);

    // Underflow, then reset clears stickies
    ifc.pop = 1'b1;
    step();
    ifc.pop = 1'b0;
    check("t3_tx_udf", 32'(ifc.tx_udf), 32'd1);
    check("t3_pndng",  32'(ifc.pndng),  32'd0);
    do_reset();
    check("t3_udf_clr", 32'(ifc.tx_udf), 32'd0);
    check("t3_ovf_clr", 32'(ifc.tx_ovf), 32'd0);

    // RX address filter (id 3, broadcast FF)
    ifc.push = 1'b1;
    ifc.D_push = 16'h0311; rx_q.push_back(16'h0311);
    step();
    check("t4_rx_head", 32'(ifc.rx_dout), 32'h0311);
    ifc.D_push = 16'h05AA;
    step();
    ifc.D_push = 16'hFFBB; rx_q.push_back(16'hFFBB);
    step();
    ifc.push = 1'b0;
    check("t4_drop", 32'(ifc.rx_drop_cnt), 32'd1);
    ifc.rx_pop = 1'b1;
    repeat (2) step();
    ifc.rx_pop = 1'b0;
    check("t4_rx_empty", 32'(ifc.rx_pndng), 32'd0);
    check("t4_rx_dout0", 32'(ifc.rx_dout),  32'd0);
    check("t4_rx_ovf0",  32'(ifc.rx_ovf),   32'd0);

    // RX overflow and drop counter saturation
    do_reset();
    ifc.push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ifc.D_push = 16'h0300 + 16'(i);
      rx_q.push_back(16'h0300 + 16'(i));
      step();
    end
    ifc.D_push = 16'h0308;
    step();
    ifc.push = 1'b0;
    check("t5_rx_ovf",  32'(ifc.rx_ovf),      32'd1);
    check("t5_drop1",   32'(ifc.rx_drop_cnt), 32'd1);
    ifc.push = 1'b1;
    ifc.D_push = 16'h0700;
    repeat (300) step();
    ifc.push = 1'b0;
    check("t5_drop_sat", 32'(ifc.rx_drop_cnt), 32'd255);
    ifc.rx_pop = 1'b1;
    repeat (9) step();
    ifc.rx_pop = 1'b0;
    check("t5_rx_empty", 32'(ifc.rx_pndng), 32'd0);
    check("t5_ovf_kept", 32'(ifc.rx_ovf),   32'd1);

    // Reset mid-stream with both FIFOs occupied and traffic active
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ifc.host_push = 1'b1;
      ifc.host_din  = 16'h2000 + 16'(i);
      if (i < 2) begin
        ifc.push   = 1'b1;
        ifc.D_push = 16'h0320 + 16'(i);
      end else ifc.push = 1'b0;
      step();
    end
    ifc.host_din = 16'h2003; ifc.pop = 1'b1;
    ifc.push = 1'b1; ifc.D_push = 16'h0322; ifc.rx_pop = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    tx_q.delete();
    rx_q.delete();
    check_reset_state("mid");
    ifc.host_push = 1'b1; ifc.host_din = 16'h0AAA; tx_q.push_back(16'h0AAA);
    ifc.push = 1'b1; ifc.D_push = 16'h03CC; rx_q.push_back(16'h03CC);
    step();
    idle();
    check("t6_head",    32'(ifc.D_pop),   32'h0AAA);
    check("t6_rx_head", 32'(ifc.rx_dout), 32'h03CC);
    ifc.pop = 1'b1; ifc.rx_pop = 1'b1;
    step();
    idle();
    check("t6_pndng",    32'(ifc.pndng),    32'd0);
    check("t6_rx_pndng", 32'(ifc.rx_pndng), 32'd0);

    check("end_tx_q_empty", 32'(tx_q.size()), 32'd0);
    check("end_rx_q_empty", 32'(rx_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_fifo_terminal.md
Name: bus_fifo_terminal

Overview:
- Device-side endpoint of the bs_gnrtr_n_rbtr bus: the responder to the bus driver's pop/pndng/D_pop read handshake and the receiver of its push/D_push writes.
- Contains a TX FIFO, loaded by the local host and drained by the bus, and an RX FIFO, loaded by the bus with an address filter and drained by the local host.
- One instance per bus terminal; DRVS instances together complete the bus for system-level simulation.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
- depth, 8, entries per FIFO; power of two, at least 2.
- id, 0, this terminal's 8-bit address.
- bcast, 8'hFF, broadcast destination ID, accepted by every terminal.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- host_push  in  1  write host_din into TX FIFO.
- host_din  in  pckg_sz  TX packet from host.
- host_full  out  1  TX FIFO full.
- pndng  out  1  TX FIFO non-empty (to bus driver).
- D_pop  out  pckg_sz  TX head packet (to bus driver).
- pop  in  1  bus driver consumes TX head.
- push  in  1  bus driver delivers a packet.
- D_push  in  pckg_sz  delivered packet.
- rx_pndng  out  1  RX FIFO non-empty.
- rx_dout  out  pckg_sz  RX head packet.
- rx_pop  in  1  host consumes RX head.
- tx_ovf  out  1  sticky: host_push dropped while full.
- tx_udf  out  1  sticky: pop received while empty.
- rx_ovf  out  1  sticky: accepted push dropped while RX full.
- rx_drop_cnt  out  8  count of filtered and overflow-dropped pushes; saturates at 255.

Behaviour:
- Reset (reset=1 at a clk edge): pointers and counts cleared; pndng=0, rx_pndng=0, host_full=0; D_pop=0, rx_dout=0; all sticky flags=0; rx_drop_cnt=0. Reset overrides any simultaneous push/pop, and contents in flight are discarded.
- Both FIFOs are first-word fall-through:
  - D_pop and rx_dout are valid whenever pndng or rx_pndng is 1.
  - D_pop and rx_dout return 0 when the FIFO is empty.
- TX write:
  - host_push with count<depth stores host_din at wr_ptr; count increments at the next edge.
  - A packet pushed into an empty FIFO appears on D_pop with pndng=1 one cycle after the push edge.
- TX read: pop with pndng=1 advances rd_ptr; the next entry is on D_pop the following cycle.
- Bus driver contract: the driver samples D_pop in the same cycle it asserts pop.
- Pointers wrap modulo depth.
- TX simultaneous cases:
  - push+pop when full: both are performed; count stays at depth; host_full stays 1; tx_ovf is not set.
  - push+pop when empty: the pop is ignored and tx_udf is set; the push is performed.
  - push when full without pop: the push is dropped; tx_ovf is set; the FIFO is unchanged.
  - pop when empty: ignored; tx_udf is set.
- host_full = (count==depth), registered with count.
- RX accept rule: a push is accepted when D_push[pckg_sz-1:pckg_sz-8] equals id or bcast. A push that fails the filter is discarded and rx_drop_cnt increments.
- RX accepted push:
  - count<depth, or count==depth with rx_pop in the same cycle: written.
  - Full without rx_pop: dropped; rx_ovf is set; rx_drop_cnt increments.
- rx_pop when empty: ignored, with no flag.
- rx_drop_cnt saturates at 255 and holds.
- Sticky flags and the counter clear only on reset.
- TX and RX paths are fully independent; all events in a single cycle are legal.

Test Plan:
- Reset, then host pushes 16'h0123 and 16'h0456 on consecutive cycles → pndng=1 and D_pop=16'h0123 one cycle after the first push; pop → D_pop=16'h0456; second pop → pndng=0, D_pop=0.
- With depth=8, host pushes 9 packets and no pop → host_full=1 after the 8th push, 9th dropped, tx_ovf=1; then push+pop in the same cycle → count stays 8; the popped order is the first 8 packets intact.
- pop with TX empty → tx_udf=1, pndng stays 0; then reset → tx_udf=0.
- id=3: push D_push=16'h0311, then 16'h05AA, then 16'hFFBB → rx_dout sequence 16'h0311, then 16'hFFBB; rx_drop_cnt=1.
- Fill RX with 8 accepted packets, then one more push → rx_ovf=1, rx_drop_cnt=1; then 300 filtered pushes → rx_drop_cnt=255.
- Assert reset mid-stream with TX holding 3 entries, RX holding 2, and push/pop active → next cycle all outputs are at reset values, and subsequent traffic behaves as from a fresh start.
